// File: rtl/dmux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer with a one-beat slot per output channel.
// Beats are routed either by in_sel (addressed) or by an internal round-robin pointer.
module dmux_1ton_stream #(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 8,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic [7:0]              drop_cnt
);

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             accept;
  logic             drop_beat;
  logic [N_OUT-1:0] fill;

  assign tgt       = mode ? rr_ptr : in_sel;
  assign tgt_ok    = ({1'b0, tgt} < (SEL_W+1)'(N_OUT));
  assign accept    = in_valid & in_ready & tgt_ok;
  assign drop_beat = in_valid & ~tgt_ok;

  // A full slot that drains this cycle can take the next beat at the same edge.
  always_comb begin
    in_ready = 1'b1;
    if (tgt_ok) in_ready = ~out_valid[tgt] | out_ready[tgt];
  end

  always_comb begin
    fill = '0;
    for (int k = 0; k < N_OUT; k++) fill[k] = accept && (tgt == SEL_W'(k));
  end

  // NOTE: the payload slots are plain flops, not a RAM, so they take the reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every slot update using pre-edge values.
      for (int k = 0; k < N_OUT; k++) begin
        if (fill[k]) begin
          out_valid[k]                   <= 1'b1;
          out_data[k*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && mode) begin
      rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_beat && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmux_1ton_stream.sv
// Bench for dmux_1ton_stream: an 8-channel and a 6-channel instance checked every cycle
// against a slot-level model, plus directed scenarios with literal expectations.
module tb_dmux_1ton_stream;

  typedef struct {
    logic [7:0]      full;
    logic [7:0][7:0] data;
    int              rr;
    int              drop;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mode = 0, in_valid = 0, in_ready;
  logic [7:0]  in_data = 0;
  logic [2:0]  in_sel = 0;
  logic [7:0]  out_valid, out_ready = 0;
  logic [63:0] out_data;
  logic [2:0]  rr_ptr;
  logic [7:0]  drop_cnt;

  logic        mode_b = 0, in_valid_b = 0, in_ready_b;
  logic [7:0]  in_data_b = 0;
  logic [2:0]  in_sel_b = 0;
  logic [5:0]  out_valid_b, out_ready_b = 0;
  logic [47:0] out_data_b;
  logic [2:0]  rr_ptr_b;
  logic [7:0]  drop_cnt_b;

  dmux_1ton_stream #(.DATA_W(8), .N_OUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .rr_ptr(rr_ptr), .drop_cnt(drop_cnt));

  dmux_1ton_stream #(.DATA_W(8), .N_OUT(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_sel(in_sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .rr_ptr(rr_ptr_b), .drop_cnt(drop_cnt_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.full = '0;
    m.data = '0;
    m.rr   = 0;
    m.drop = 0;
    return m;
  endfunction

  function automatic bit exp_ready(model_t m, int n, bit md, int sel, logic [7:0] ordy);
    int t = md ? m.rr : sel;
    if (t >= n) return 1'b1;
    return !m.full[t] || ordy[t];
  endfunction

  // One clock edge of the spec: drains first, then an accepted beat occupies its slot.
  function automatic model_t model_step(model_t m, int n, bit md, int sel, bit vld,
                                        logic [7:0] d, logic [7:0] ordy);
    model_t r = m;
    int t = md ? m.rr : sel;
    for (int k = 0; k < n; k++) if (m.full[k] && ordy[k]) r.full[k] = 1'b0;
    if (vld) begin
      if (t >= n) begin
        if (r.drop < 255) r.drop++;
      end else if (!m.full[t] || ordy[t]) begin
        r.full[t] = 1'b1;
        r.data[t] = d;
        if (md) r.rr = (m.rr + 1) % n;
      end
    end
    return r;
  endfunction

  model_t ma, mb;

  always @(negedge clk) begin
    if (!rst_n) begin
      ma = model_reset();
      mb = model_reset();
    end
    check("a.in_ready", in_ready, exp_ready(ma, 8, mode, in_sel, out_ready));
    check("a.out_valid", out_valid, ma.full);
    for (int k = 0; k < 8; k++)
      check($sformatf("a.out_data[%0d]", k), out_data[k*8 +: 8], ma.data[k]);
    check("a.rr_ptr", rr_ptr, ma.rr);
    check("a.drop_cnt", drop_cnt, ma.drop);
    check("b.in_ready", in_ready_b, exp_ready(mb, 6, mode_b, in_sel_b, {2'b0, out_ready_b}));
    check("b.out_valid", out_valid_b, mb.full[5:0]);
    for (int k = 0; k < 6; k++)
      check($sformatf("b.out_data[%0d]", k), out_data_b[k*8 +: 8], mb.data[k]);
    check("b.rr_ptr", rr_ptr_b, mb.rr);
    check("b.drop_cnt", drop_cnt_b, mb.drop);
    if (rst_n) begin
      ma = model_step(ma, 8, mode, in_sel, in_valid, in_data, out_ready);
      mb = model_step(mb, 6, mode_b, in_sel_b, in_valid_b, in_data_b, {2'b0, out_ready_b});
    end
  end

  // Offers one beat and returns just after the edge that accepted it.
  task automatic send(input logic [2:0] sel, input logic [7:0] d);
    bit ok = 0;
    in_valid = 1; in_sel = sel; in_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("a.send_accepted", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_b(input logic [2:0] sel, input logic [7:0] d);
    bit ok = 0;
    in_valid_b = 1; in_sel_b = sel; in_data_b = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1; break; end
    end
    check("b.send_accepted", ok, 1'b1);
    @(posedge clk); #1;
    in_valid_b = 0;
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Addressed beat to channel 5 with every consumer ready.
    out_ready = 8'hFF;
    send(3'd5, 8'hA5);
    check("t2.out_valid", out_valid, 8'h20);
    check("t2.ch5", out_data[40 +: 8], 8'hA5);
    @(posedge clk); #1;

    // Back-pressure on channel 2, then refill in the cycle it drains.
    out_ready = 8'hFB;
    send(3'd2, 8'h11);
    in_valid = 1; in_sel = 3'd2; in_data = 8'h22;
    #1 check("t3.blocked", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("t3.still_blocked", in_ready, 1'b0);
    check("t3.ch2_held", out_data[16 +: 8], 8'h11);
    @(posedge clk); #1 out_ready = 8'hFF;
    #1 check("t3.unblocked", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 0;
    check("t3.ch2_valid", out_valid[2], 1'b1);
    check("t3.ch2_new", out_data[16 +: 8], 8'h22);
    @(posedge clk); #1;

    // Round-robin: ten beats wrap past channel 7.
    mode = 1;
    for (int i = 0; i < 10; i++) send(3'd0, 8'(i));
    check("t4.rr_ptr", rr_ptr, 3'd2);
    check("t4.ch0", out_data[0 +: 8], 8'h08);
    check("t4.ch1", out_data[8 +: 8], 8'h09);
    check("t4.ch7", out_data[56 +: 8], 8'h07);

    // Round-robin stall on a full, non-draining channel 3.
    out_ready = 8'hF7;
    for (int i = 0; i < 9; i++) send(3'd0, 8'(8'h50 + i));
    check("t5.rr_at_3", rr_ptr, 3'd3);
    in_valid = 1; in_data = 8'h60;
    #1 check("t5.stall", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("t5.stall_rr", rr_ptr, 3'd3);
    check("t5.stall_ready", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 8'hFF;
    #1 check("t5.release", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 0;
    check("t5.rr_after", rr_ptr, 3'd4);
    check("t5.ch3", out_data[24 +: 8], 8'h60);

    // Six-channel instance: last legal channel, first illegal one, then a drop flood.
    out_ready_b = 6'h3F;
    send_b(3'd5, 8'h5C);
    check("t6.ch5_valid", out_valid_b, 6'h20);
    in_valid_b = 1; in_sel_b = 3'd6; in_data_b = 8'hEE;
    @(posedge clk); #1;
    check("t6.drop_one", drop_cnt_b, 8'd1);
    in_sel_b = 3'd7;
    repeat (300) @(posedge clk);
    #1 in_valid_b = 0;
    check("t6.drop_sat", drop_cnt_b, 8'd255);
    check("t6.out_valid", out_valid_b, 6'h00);
    check("t6.ch5_kept", out_data_b[40 +: 8], 8'h5C);

    // Asynchronous reset with slots full and the pointer away from zero.
    out_ready = 8'h00;
    send(3'd0, 8'h33);
    send(3'd0, 8'h44);
    check("t1.pre_valid", out_valid, 8'h30);
    #2 rst_n = 0;
    #1;
    check("t1.out_valid", out_valid, 8'h00);
    check("t1.out_data", out_data, 64'h0);
    check("t1.rr_ptr", rr_ptr, 3'd0);
    check("t1.drop_cnt", drop_cnt_b, 8'd0);
    @(posedge clk); #1 rst_n = 1;

    // Addressed traffic after reset.
    mode = 0; out_ready = 8'hFF;
    send(3'd7, 8'h77);
    check("post.ch7", out_data[56 +: 8], 8'h77);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
